alu_op_dispatch: RTL and testbench
==================================

Name: alu_op_dispatch

Overview:
- Producer side of the 32-bit datapath ALU interface.
- Accepts decoded MIPS instruction fields plus register-file operand values.
- Translates each opcode/funct into the ALU's 4-bit ctrl code and selects the a/b operands.
- Buffers results in a small in-order queue and presents {a, b, ctrl} to the ALU issue slot with a valid/ready handshake.

Parameters:
- DEPTH, 4, queue entries; power of two, minimum 2.
- TAG_W, 6, width of the opaque instruction tag carried alongside the operands.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- flush  input  1  synchronous queue clear (branch mispredict).
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  queue can accept; equals (count < DEPTH); no combinational path from out_ready.
- in_opcode  input  6  instr[31:26].
- in_funct  input  6  instr[5:0].
- in_shamt  input  5  instr[10:6].
- in_imm  input  16  instr[15:0].
- in_rs_val  input  32  rs operand value.
- in_rt_val  input  32  rt operand value.
- in_tag  input  TAG_W  passed through unchanged.
- out_valid  output  1  head entry valid.
- out_ready  input  1  ALU slot accepts.
- out_a  output  32  ALU operand a.
- out_b  output  32  ALU operand b.
- out_ctrl  output  4  ALU ctrl code.
- out_tag  output  TAG_W  tag of the head entry.
- out_illegal  output  1  head entry has an unsupported encoding.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst=0 at a clock edge): queue empties. Outputs after reset: count=0, out_valid=0, in_ready=1. out_a/out_b/out_tag=0, out_ctrl=4'b1111, out_illegal=0.
- Decode happens at enqueue; each entry stores {a, b, ctrl, tag, illegal}.
- ALU ctrl codes: AND 0000, OR 0001, XOR 0010, NOR 0011, ADD 0100, ADDU 0101, SUB 0110, SUBU 0111, SLT 1000, SLTU 1001, SLL 1010, SRL 1011, SRA 1100, LUI 1101.
- R-type (opcode 000000), default a=rs, b=rt:
  - funct 100000..100111 map to ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR.
  - funct 101010 maps to SLT; 101011 maps to SLTU.
  - funct 000000/000010/000011 map to SLL/SRL/SRA with a={27'b0,shamt}, b=rt.
  - funct 000100/000110/000111 map to SLLV/SRLV/SRAV with a={27'b0,rs[4:0]}, b=rt.
- I-type, a=rs:
  - 001000 ADDI maps to ADD with sign-extended imm.
  - 001001 maps to ADDU, 001010 to SLT, 001011 to SLTU; all with sign-extended imm.
  - 001100/001101/001110 (ANDI/ORI/XORI) map to AND/OR/XOR with zero-extended imm.
  - 001111 LUI maps to ctrl 1101 with a=0, b={16'b0,imm}.
- Any other encoding: ctrl=1111, a=b=0, illegal=1. The entry is still queued so the exception retires in order.
- Push when in_valid & in_ready. Pop when out_valid & out_ready.
- Latency: an entry pushed at edge N is visible at the output from cycle N+1.
- Order is strictly FIFO. Pointers wrap modulo DEPTH.
- Push and pop in the same cycle: count is unchanged.
  - When full, in_ready=0, so no push occurs even if a pop happens that cycle.
- Empty: out_valid=0. out_* hold the last popped values; their value is don't-care to consumers.
- Output stability: head outputs stay stable while out_valid & ~out_ready.
- flush=1: queue empties at the edge (count=0, out_valid=0 next cycle). A push or pop in that same cycle is discarded.
- rst has priority over flush.
- Reset mid-stream: all entries are discarded with no partial state left.

Optional Feature:
- ALU_DISPATCH_BYPASS_EN: when defined, an empty queue gives a zero-latency bypass.
  - Condition: count=0 & in_valid & ~flush.
  - out_valid=1 in the same cycle, with out_* driven combinationally from the decoder.
  - If out_ready is also high, the entry is consumed and not enqueued.
  - If out_ready is low, the entry is enqueued normally.
- When undefined, minimum latency is 1 cycle and out_* come only from storage.

Decomposition:
- Shared header alu_defs.vh:
  - ALU ctrl localparams (CTRL_AND ... CTRL_LUI, CTRL_NOP=4'b1111).
  - Opcode and funct localparams.
  - Reused by the ALU and by the control unit.
- One combinational sub-module, alu_op_decode:
  - Inputs: opcode, funct, shamt, imm, rs, rt.
  - Outputs: a, b, ctrl, illegal.
- Queue storage and pointers live in alu_op_dispatch.

Test Plan:
- Reset, then addi rs=5 imm=0xFFFF -> next cycle out_valid=1, out_a=5, out_b=0xFFFFFFFF, out_ctrl=0100, illegal=0.
- sra shamt=4 rt=0x80000000, then srav rs=0x00000024 -> first entry a=4, ctrl=1100; second entry a=4 (rs masked to 5 bits), b=0x80000000.
- Hold out_ready=0, push 5 entries -> the 5th is not accepted (in_ready=0 after the 4th, count=4). Raise out_ready -> entries drain in push order, one per cycle.
- Full queue, simultaneous pop and in_valid -> count goes 4 to 3 and the push is refused.
- Steady state, push+pop every cycle -> count unchanged.
- opcode 000010 (j) -> out_ctrl=1111, out_illegal=1, tag preserved. Then ori imm=0x8000 -> b=0x00008000. Then lui imm=0x1234 -> ctrl=1101, b=0x1234, a=0.
- 3 entries queued, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0. Reset asserted mid-stream -> count=0, out_ctrl=1111.

Source files
------------

// File: rtl/alu_op_dispatch_pkg.sv
// alu_op_dispatch_pkg: ALU ctrl codes, MIPS opcode/funct encodings and queue entry type
package alu_op_dispatch_pkg;
  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_XOR  = 4'b0010;
  localparam logic [3:0] CTRL_NOR  = 4'b0011;
  localparam logic [3:0] CTRL_ADD  = 4'b0100;
  localparam logic [3:0] CTRL_ADDU = 4'b0101;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_SUBU = 4'b0111;
  localparam logic [3:0] CTRL_SLT  = 4'b1000;
  localparam logic [3:0] CTRL_SLTU = 4'b1001;
  localparam logic [3:0] CTRL_SLL  = 4'b1010;
  localparam logic [3:0] CTRL_SRL  = 4'b1011;
  localparam logic [3:0] CTRL_SRA  = 4'b1100;
  localparam logic [3:0] CTRL_LUI  = 4'b1101;
  localparam logic [3:0] CTRL_NOP  = 4'b1111;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic        illegal;
  } uop_t;
  localparam uop_t UOP_NOP = '{a: 32'd0, b: 32'd0, ctrl: CTRL_NOP, illegal: 1'b0};
endpackage

// File: rtl/alu_op_dispatch_decode.sv
// alu_op_decode: maps MIPS opcode/funct to ALU ctrl code and a/b operands
module alu_op_decode
  import alu_op_dispatch_pkg::*;
(
  input  logic [5:0]  i_opcode,
  input  logic [5:0]  i_funct,
  input  logic [4:0]  i_shamt,
  input  logic [15:0] i_imm,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  output logic [31:0] o_a,
  output logic [31:0] o_b,
  output logic [3:0]  o_ctrl,
  output logic        o_illegal
);
  logic [31:0] w_sext;
  logic [31:0] w_zext;
  assign w_sext = {{16{i_imm[15]}}, i_imm};
  assign w_zext = {16'd0, i_imm};
  // decode table; unsupported encodings collapse to a zero-operand NOP flagged illegal
  always_comb begin
    o_a = i_rs;
    o_b = i_rt;
    o_ctrl = CTRL_NOP;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_RTYPE: case (i_funct)
        F_ADD:  o_ctrl = CTRL_ADD;
        F_ADDU: o_ctrl = CTRL_ADDU;
        F_SUB:  o_ctrl = CTRL_SUB;
        F_SUBU: o_ctrl = CTRL_SUBU;
        F_AND:  o_ctrl = CTRL_AND;
        F_OR:   o_ctrl = CTRL_OR;
        F_XOR:  o_ctrl = CTRL_XOR;
        F_NOR:  o_ctrl = CTRL_NOR;
        F_SLT:  o_ctrl = CTRL_SLT;
        F_SLTU: o_ctrl = CTRL_SLTU;
        F_SLL:  begin o_ctrl = CTRL_SLL; o_a = {27'd0, i_shamt}; end
        F_SRL:  begin o_ctrl = CTRL_SRL; o_a = {27'd0, i_shamt}; end
        F_SRA:  begin o_ctrl = CTRL_SRA; o_a = {27'd0, i_shamt}; end
        F_SLLV: begin o_ctrl = CTRL_SLL; o_a = {27'd0, i_rs[4:0]}; end
        F_SRLV: begin o_ctrl = CTRL_SRL; o_a = {27'd0, i_rs[4:0]}; end
        F_SRAV: begin o_ctrl = CTRL_SRA; o_a = {27'd0, i_rs[4:0]}; end
        default: o_illegal = 1'b1;
      endcase
      OP_ADDI:  begin o_ctrl = CTRL_ADD;  o_b = w_sext; end
      OP_ADDIU: begin o_ctrl = CTRL_ADDU; o_b = w_sext; end
      OP_SLTI:  begin o_ctrl = CTRL_SLT;  o_b = w_sext; end
      OP_SLTIU: begin o_ctrl = CTRL_SLTU; o_b = w_sext; end
      OP_ANDI:  begin o_ctrl = CTRL_AND;  o_b = w_zext; end
      OP_ORI:   begin o_ctrl = CTRL_OR;   o_b = w_zext; end
      OP_XORI:  begin o_ctrl = CTRL_XOR;  o_b = w_zext; end
      OP_LUI:   begin o_ctrl = CTRL_LUI;  o_a = 32'd0; o_b = w_zext; end
      default:  o_illegal = 1'b1;
    endcase
    if (o_illegal) begin
      o_a = 32'd0;
      o_b = 32'd0;
      o_ctrl = CTRL_NOP;
    end
  end
endmodule

// File: rtl/alu_op_dispatch.sv
// alu_op_dispatch: decode-at-enqueue in-order queue feeding the ALU issue slot; optional ALU_DISPATCH_BYPASS_EN
module alu_op_dispatch
  import alu_op_dispatch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [5:0]               in_opcode,
  input  logic [5:0]               in_funct,
  input  logic [4:0]               in_shamt,
  input  logic [15:0]              in_imm,
  input  logic [31:0]              in_rs_val,
  input  logic [31:0]              in_rt_val,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_a,
  output logic [31:0]              out_b,
  output logic [3:0]               out_ctrl,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  uop_t             r_mem [DEPTH];
  logic [TAG_W-1:0] r_tag [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  uop_t             r_last;
  logic [TAG_W-1:0] r_last_tag;
  logic [31:0]      w_a;
  logic [31:0]      w_b;
  logic [3:0]       w_ctrl;
  logic             w_ill;
  uop_t             w_dec;
  uop_t             w_head;
  logic [TAG_W-1:0] w_head_tag;
  logic             w_empty;
  logic             w_byp;
  logic             w_push;
  logic             w_pop;
  alu_op_decode u_dec (
    .i_opcode  (in_opcode),
    .i_funct   (in_funct),
    .i_shamt   (in_shamt),
    .i_imm     (in_imm),
    .i_rs      (in_rs_val),
    .i_rt      (in_rt_val),
    .o_a       (w_a),
    .o_b       (w_b),
    .o_ctrl    (w_ctrl),
    .o_illegal (w_ill)
  );
  assign w_dec = '{a: w_a, b: w_b, ctrl: w_ctrl, illegal: w_ill};
  assign w_empty = r_count == '0;
`ifdef ALU_DISPATCH_BYPASS_EN
  assign w_byp = w_empty & in_valid & ~flush;
`else
  assign w_byp = 1'b0;
`endif
  assign in_ready = r_count < FULL;
  assign out_valid = ~w_empty | w_byp;
  assign w_head = w_byp ? w_dec : w_empty ? r_last : r_mem[r_rptr];
  assign w_head_tag = w_byp ? in_tag : w_empty ? r_last_tag : r_tag[r_rptr];
  assign w_push = in_valid & in_ready & ~(w_byp & out_ready);
  assign w_pop = ~w_empty & out_ready;
  assign out_a = w_head.a;
  assign out_b = w_head.b;
  assign out_ctrl = w_head.ctrl;
  assign out_illegal = w_head.illegal;
  assign out_tag = w_head_tag;
  assign count = r_count;
  // queue pointers, storage and the last-consumed entry shown while empty
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
      r_last <= UOP_NOP;
      r_last_tag <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_dec;
        r_tag[r_wptr] <= in_tag;
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (out_valid & out_ready) begin
        r_last <= w_head;
        r_last_tag <= w_head_tag;
      end
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: tb/tb_alu_op_dispatch.sv
// tb_alu_op_dispatch: directed stimulus against a queue-based reference model
module tb_alu_op_dispatch;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic        ill;
    logic [5:0]  tag;
  } ent_t;
  logic clk = 0;
  logic rst = 0;
  logic flush = 0;
  logic in_valid = 0;
  logic in_ready;
  logic [5:0] in_opcode = 0;
  logic [5:0] in_funct = 0;
  logic [4:0] in_shamt = 0;
  logic [15:0] in_imm = 0;
  logic [31:0] in_rs_val = 0;
  logic [31:0] in_rt_val = 0;
  logic [5:0] in_tag = 0;
  logic out_valid;
  logic out_ready = 0;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [3:0] out_ctrl;
  logic [5:0] out_tag;
  logic out_illegal;
  logic [2:0] count;
  int checks = 0;
  int failures = 0;
  ent_t q[$];
  alu_op_dispatch #(.DEPTH(4), .TAG_W(6)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct(in_funct), .in_shamt(in_shamt), .in_imm(in_imm),
    .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_ctrl(out_ctrl), .out_tag(out_tag), .out_illegal(out_illegal), .count(count)
  );
  always #5 clk = ~clk;
  function automatic ent_t model(input int op, input int fn, input int sh, input int imm,
                                 input logic [31:0] rs, input logic [31:0] rt, input logic [5:0] tag);
    int rtab[8] = '{4, 5, 6, 7, 0, 1, 2, 3};
    int itab[7] = '{4, 5, 8, 9, 0, 1, 2};
    logic [31:0] sext = imm >= 32768 ? 32'(imm) + 32'hFFFF0000 : 32'(imm);
    ent_t e;
    e.a = rs; e.b = rt; e.ctrl = 4'hF; e.ill = 0; e.tag = tag;
    if (op == 0 && fn >= 32 && fn <= 39) e.ctrl = 4'(rtab[fn-32]);
    else if (op == 0 && fn == 42) e.ctrl = 8;
    else if (op == 0 && fn == 43) e.ctrl = 9;
    else if (op == 0 && (fn == 0 || fn == 2 || fn == 3)) begin
      e.ctrl = fn == 0 ? 4'd10 : fn == 2 ? 4'd11 : 4'd12;
      e.a = 32'(sh);
    end else if (op == 0 && (fn == 4 || fn == 6 || fn == 7)) begin
      e.ctrl = fn == 4 ? 4'd10 : fn == 6 ? 4'd11 : 4'd12;
      e.a = rs % 32;
    end else if (op >= 8 && op <= 14) begin
      e.ctrl = 4'(itab[op-8]);
      e.b = op <= 11 ? sext : 32'(imm);
    end else if (op == 15) begin
      e.ctrl = 13; e.a = 0; e.b = 32'(imm);
    end else begin
      e.ctrl = 4'hF; e.a = 0; e.b = 0; e.ill = 1;
    end
    return e;
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  // reference model advances on every clock edge from the driven inputs
  always @(posedge clk) begin
    if (!rst || flush) q.delete();
    else begin
      automatic bit do_push = in_valid && q.size() < 4;
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (do_push) q.push_back(model(in_opcode, in_funct, in_shamt, in_imm, in_rs_val, in_rt_val, in_tag));
    end
  end
  // per-cycle comparison of DUT against the model
  always @(negedge clk) begin
    if (rst) begin
      chk("m_count", 32'(count), 32'(q.size()));
      chk("m_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("m_ready", 32'(in_ready), 32'(q.size() < 4));
      if (q.size() != 0) begin
        chk("m_a", out_a, q[0].a);
        chk("m_b", out_b, q[0].b);
        chk("m_ctrl", 32'(out_ctrl), 32'(q[0].ctrl));
        chk("m_ill", 32'(out_illegal), 32'(q[0].ill));
        chk("m_tag", 32'(out_tag), 32'(q[0].tag));
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int op, input int fn, input int sh, input int imm,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [5:0] tag);
    in_valid = 1; in_opcode = 6'(op); in_funct = 6'(fn); in_shamt = 5'(sh);
    in_imm = 16'(imm); in_rs_val = rs; in_rt_val = rt; in_tag = tag;
  endtask
  task automatic push(input int op, input int fn, input int sh, input int imm,
                      input logic [31:0] rs, input logic [31:0] rt, input logic [5:0] tag);
    drive(op, fn, sh, imm, rs, rt, tag);
    step();
    in_valid = 0;
  endtask
  initial begin
    step(); step();
    @(negedge clk);
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_a", out_a, 0);
    chk("rst_b", out_b, 0);
    chk("rst_tag", 32'(out_tag), 0);
    chk("rst_ctrl", 32'(out_ctrl), 32'hF);
    chk("rst_ill", 32'(out_illegal), 0);
    step();
    rst = 1;
    push(8, 0, 0, 16'hFFFF, 5, 0, 1);
    @(negedge clk);
    chk("addi_valid", 32'(out_valid), 1);
    chk("addi_a", out_a, 5);
    chk("addi_b", out_b, 32'hFFFFFFFF);
    chk("addi_ctrl", 32'(out_ctrl), 4);
    chk("addi_ill", 32'(out_illegal), 0);
    out_ready = 1; step(); out_ready = 0;
    push(0, 3, 4, 0, 0, 32'h80000000, 2);
    push(0, 7, 0, 0, 32'h24, 32'h80000000, 3);
    @(negedge clk);
    chk("sra_a", out_a, 4);
    chk("sra_ctrl", 32'(out_ctrl), 12);
    out_ready = 1; step(); out_ready = 0;
    @(negedge clk);
    chk("srav_a", out_a, 4);
    chk("srav_b", out_b, 32'h80000000);
    chk("srav_ctrl", 32'(out_ctrl), 12);
    out_ready = 1; step();
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      drive(0, 32 + i, 0, 0, 32'(100 + i), 32'(7 * i), 6'(10 + i));
      step();
    end
    in_valid = 0;
    @(negedge clk);
    chk("full_count", 32'(count), 4);
    chk("full_ready", 32'(in_ready), 0);
    chk("full_head_tag", 32'(out_tag), 10);
    out_ready = 1;
    for (int i = 0; i < 4; i++) step();
    @(negedge clk);
    chk("drain_count", 32'(count), 0);
    out_ready = 0;
    for (int i = 0; i < 4; i++) push(12, 0, 0, 16'(i * 3), 32'hF0F0, 0, 6'(20 + i));
    drive(13, 0, 0, 16'h55, 1, 2, 6'd30);
    out_ready = 1;
    step();
    in_valid = 0; out_ready = 0;
    @(negedge clk);
    chk("fullpop_count", 32'(count), 3);
    chk("fullpop_head_tag", 32'(out_tag), 21);
    out_ready = 1;
    for (int i = 0; i < 3; i++) step();
    out_ready = 0;
    push(0, 42, 0, 0, 32'hFFFFFFFF, 1, 40);
    push(11, 0, 0, 16'h8001, 3, 0, 41);
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      drive(0, i % 2 == 0 ? 43 : 6, 0, 0, 32'(33 + i), 32'(i), 6'(42 + i));
      step();
    end
    in_valid = 0; out_ready = 0;
    @(negedge clk);
    chk("steady_count", 32'(count), 2);
    out_ready = 1; step(); step(); out_ready = 0;
    push(2, 0, 0, 0, 9, 9, 6'h2A);
    push(13, 0, 0, 16'h8000, 1, 0, 6'h2B);
    push(15, 0, 0, 16'h1234, 7, 7, 6'h2C);
    @(negedge clk);
    chk("j_ctrl", 32'(out_ctrl), 32'hF);
    chk("j_ill", 32'(out_illegal), 1);
    chk("j_tag", 32'(out_tag), 32'h2A);
    chk("j_a", out_a, 0);
    out_ready = 1; step(); out_ready = 0;
    @(negedge clk);
    chk("ori_b", out_b, 32'h00008000);
    chk("ori_ctrl", 32'(out_ctrl), 1);
    out_ready = 1; step(); out_ready = 0;
    @(negedge clk);
    chk("lui_ctrl", 32'(out_ctrl), 13);
    chk("lui_b", out_b, 32'h1234);
    chk("lui_a", out_a, 0);
    out_ready = 1; step(); out_ready = 0;
    for (int i = 0; i < 3; i++) push(0, 37, 0, 0, 32'(i), 32'(i), 6'(50 + i));
    drive(0, 32, 0, 0, 1, 1, 60);
    flush = 1;
    step();
    flush = 0; in_valid = 0;
    @(negedge clk);
    chk("flush_count", 32'(count), 0);
    chk("flush_valid", 32'(out_valid), 0);
    push(0, 38, 0, 0, 5, 6, 61);
    push(9, 0, 0, 16'hFFFE, 5, 6, 62);
    rst = 0;
    step();
    rst = 1;
    @(negedge clk);
    chk("midrst_count", 32'(count), 0);
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_ctrl", 32'(out_ctrl), 32'hF);
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
